// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time, consults the branch
// predictor when data returns, and buffers {inst, pc, predicted-jump} for dispatch.
module inst_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INST_WIDTH  = 32,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  output logic                  mc_req_valid,
  output logic [ADDR_WIDTH-1:0] mc_req_addr,
  input  logic                  mc_req_ready,
  input  logic                  mc_inst_valid,
  input  logic [INST_WIDTH-1:0] mc_inst,
  output logic                  pdc_valid,
  output logic [INST_WIDTH-1:0] pdc_inst,
  output logic [ADDR_WIDTH-1:0] pdc_pc,
  input  logic                  pdc_need_jump,
  input  logic [ADDR_WIDTH-1:0] pdc_predicted_imm,
  output logic                  dq_valid,
  output logic [INST_WIDTH-1:0] dq_inst,
  output logic [ADDR_WIDTH-1:0] dq_pc,
  output logic                  dq_pred_jump,
  input  logic                  dq_ready,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [INST_WIDTH-1:0] r_q_inst [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] r_q_pc   [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] r_q_jump;

  logic                  w_active;
  logic                  w_in_wait;
  logic [CNT_W-1:0]      w_occupancy;
  logic                  w_not_full;
  logic                  w_req_valid;
  logic                  w_ret;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_dq_valid;
  logic [ADDR_WIDTH-1:0] w_next_pc;

  // The outstanding request already owns a slot, so returned data never finds the queue full.
  assign w_active    = rdy & rst_n;
  assign w_in_wait   = (r_state == S_WAIT);
  assign w_occupancy = r_count + {{(CNT_W-1){1'b0}}, w_in_wait};
  assign w_not_full  = (w_occupancy < DEPTH_C);
  assign w_req_valid = w_active & ~flush & (r_state == S_IDLE) & w_not_full;
  assign w_ret       = w_active & w_in_wait & mc_inst_valid;
  assign w_push      = w_ret & ~flush;
  assign w_dq_valid  = (r_count != {CNT_W{1'b0}});
  assign w_pop       = w_active & ~flush & w_dq_valid & dq_ready;
  assign w_next_pc   = pdc_need_jump ? (r_pc + pdc_predicted_imm) : (r_pc + PC_STEP);

  assign mc_req_valid = w_req_valid;
  assign mc_req_addr  = w_req_valid ? r_pc : {ADDR_WIDTH{1'b0}};
  assign pdc_valid    = w_ret;
  assign pdc_inst     = w_ret ? mc_inst : {INST_WIDTH{1'b0}};
  assign pdc_pc       = w_ret ? r_pc : {ADDR_WIDTH{1'b0}};
  assign dq_valid     = w_dq_valid;
  assign dq_inst      = w_dq_valid ? r_q_inst[r_head] : {INST_WIDTH{1'b0}};
  assign dq_pc        = w_dq_valid ? r_q_pc[r_head] : {ADDR_WIDTH{1'b0}};
  assign dq_pred_jump = w_dq_valid & r_q_jump[r_head];

  // Fetch FSM, PC and queue pointers; flush overrides push, pop and PC update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else if (rdy) begin
      if (flush) begin
        r_pc    <= flush_pc;
        r_head  <= {PTR_W{1'b0}};
        r_tail  <= {PTR_W{1'b0}};
        r_count <= {CNT_W{1'b0}};
        case (r_state)
          S_WAIT:  r_state <= mc_inst_valid ? S_IDLE : S_DROP;
          S_DROP:  r_state <= mc_inst_valid ? S_IDLE : S_DROP;
          default: r_state <= S_IDLE;
        endcase
      end else begin
        if (w_push) begin
          r_tail <= r_tail + PTR_W'(1);
          r_pc   <= w_next_pc;
        end
        if (w_pop) begin
          r_head <= r_head + PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
        case (r_state)
          S_IDLE:  if (w_req_valid && mc_req_ready) r_state <= S_WAIT;
          S_WAIT:  if (mc_inst_valid) r_state <= S_IDLE;
          S_DROP:  if (mc_inst_valid) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Queue storage, written at the tail on each accepted return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_q_inst[i] <= {INST_WIDTH{1'b0}};
        r_q_pc[i]   <= {ADDR_WIDTH{1'b0}};
      end
      r_q_jump <= {QUEUE_DEPTH{1'b0}};
    end else if (w_push) begin
      r_q_inst[r_tail] <= mc_inst;
      r_q_pc[r_tail]   <= r_pc;
      r_q_jump[r_tail] <= pdc_need_jump;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed scenarios push expected requests and
// queue entries; a monitor pops and compares whenever the DUT presents them.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, rdy;
  logic        mc_req_valid, mc_req_ready, mc_inst_valid;
  logic [31:0] mc_req_addr, mc_inst;
  logic        pdc_valid, pdc_need_jump;
  logic [31:0] pdc_inst, pdc_pc, pdc_predicted_imm;
  logic        dq_valid, dq_pred_jump, dq_ready;
  logic [31:0] dq_inst, dq_pc;
  logic        flush;
  logic [31:0] flush_pc;

  logic dq_ready_r, pop_on_push, jump_en;
  int   mem_lat, req_target, req_done;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pj;
  } ent_t;
  ent_t        exp_ent[$];
  logic [31:0] exp_req[$];

  always #5 clk = ~clk;

  assign mc_req_ready      = (req_done < req_target);
  assign dq_ready          = pop_on_push ? mc_inst_valid : dq_ready_r;
  assign pdc_need_jump     = pdc_valid & jump_en & (pdc_pc == 32'h0000_0010);
  assign pdc_predicted_imm = 32'hFFFF_FFF8;

  inst_fetch_unit #(.ADDR_WIDTH(32), .INST_WIDTH(32), .QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .mc_req_valid(mc_req_valid), .mc_req_addr(mc_req_addr), .mc_req_ready(mc_req_ready),
    .mc_inst_valid(mc_inst_valid), .mc_inst(mc_inst),
    .pdc_valid(pdc_valid), .pdc_inst(pdc_inst), .pdc_pc(pdc_pc),
    .pdc_need_jump(pdc_need_jump), .pdc_predicted_imm(pdc_predicted_imm),
    .dq_valid(dq_valid), .dq_inst(dq_inst), .dq_pc(dq_pc), .dq_pred_jump(dq_pred_jump),
    .dq_ready(dq_ready), .flush(flush), .flush_pc(flush_pc)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[19:0], 12'h013};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_ent(input logic [31:0] pc, input logic [31:0] inst, input logic pj);
    exp_ent.push_back({pc, inst, pj});
  endtask

  task automatic wait_req(input int tgt, input string name);
    int k = 0;
    while (req_done < tgt && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(req_done >= tgt), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_req.size() != 0 || exp_ent.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(exp_req.size() + exp_ent.size()), 32'd0);
  endtask

  // Memory model: accepts a request, returns inst_of(addr) mem_lat cycles later for one cycle.
  initial begin : mem_model
    int          cnt;
    logic        pend, acc, fire;
    logic [31:0] paddr, a_addr;
    cnt = 0; pend = 1'b0; paddr = 32'h0; req_done = 0;
    mc_inst_valid = 1'b0; mc_inst = 32'h0;
    forever begin
      @(negedge clk);
      acc    = rst_n && rdy && mc_req_valid && mc_req_ready;
      a_addr = mc_req_addr;
      fire   = rst_n && rdy && mc_inst_valid;
      @(posedge clk);
      #1;
      if (fire) begin
        mc_inst_valid = 1'b0;
        mc_inst       = 32'h0;
        pend          = 1'b0;
      end
      if (acc) begin
        pend  = 1'b1;
        cnt   = mem_lat;
        paddr = a_addr;
        req_done++;
      end
      if (pend && !mc_inst_valid) begin
        if (cnt <= 1) begin
          mc_inst_valid = 1'b1;
          mc_inst       = inst_of(paddr);
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: compares accepted requests, popped queue heads and predictor lookups.
  initial begin : monitor
    ent_t        e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (rst_n && rdy && mc_req_valid && mc_req_ready) begin
        if (exp_req.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL req_unexpected: got request at 0x%0h, expected none", mc_req_addr);
        end else begin
          a = exp_req.pop_front();
          check("req_addr", mc_req_addr, a);
        end
      end
      if (rst_n && rdy && !flush && dq_valid && dq_ready) begin
        if (exp_ent.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL dq_unexpected: got entry pc 0x%0h, expected none", dq_pc);
        end else begin
          e = exp_ent.pop_front();
          check("dq_pc", dq_pc, e.pc);
          check("dq_inst", dq_inst, e.inst);
          check("dq_pred_jump", 32'(dq_pred_jump), 32'(e.pj));
        end
      end
      if (pdc_valid) check("pdc_inst", pdc_inst, inst_of(pdc_pc));
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; flush_pc = 32'h0;
    dq_ready_r = 1'b1; pop_on_push = 1'b0; jump_en = 1'b0;
    mem_lat = 1; req_target = 3;
    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(mc_req_valid), 32'd0);
    check("rst_req_addr", mc_req_addr, 32'h0);
    check("rst_pdc_valid", 32'(pdc_valid), 32'd0);
    check("rst_dq_valid", 32'(dq_valid), 32'd0);
    check("rst_dq_pc", dq_pc, 32'h0);
    check("rst_dq_inst", dq_inst, 32'h0);
    check("rst_dq_pj", 32'(dq_pred_jump), 32'd0);

    // Sequential fetch from reset
    exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
    add_ent(32'h0, 32'h0000_0013, 1'b0);
    add_ent(32'h4, 32'h0000_4013, 1'b0);
    add_ent(32'h8, 32'h0000_8013, 1'b0);
    tick(); rst_n = 1'b1;
    wait_req(3, "s27_reqs");
    wait_drain("s27_drain");
    @(negedge clk);
    check("s27_next_addr", mc_req_addr, 32'hC);

    // Predicted-taken branch at 0x10 back to 0x08
    tick(); jump_en = 1'b1;
    exp_req.push_back(32'hC); exp_req.push_back(32'h10); exp_req.push_back(32'h8);
    add_ent(32'hC,  32'h0000_C013, 1'b0);
    add_ent(32'h10, 32'h0001_0013, 1'b1);
    add_ent(32'h8,  32'h0000_8013, 1'b0);
    req_target = 6;
    wait_req(6, "s28_reqs");
    wait_drain("s28_drain");
    tick(); jump_en = 1'b0;
    @(negedge clk);
    check("s28_next_addr", mc_req_addr, 32'hC);

    // Queue fills with consumer stalled, one pop frees exactly one request
    tick(); dq_ready_r = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_req.push_back(32'hC + 32'(4 * i));
      add_ent(32'hC + 32'(4 * i), inst_of(32'hC + 32'(4 * i)), 1'b0);
    end
    req_target = 11;
    wait_req(10, "s29_four_reqs");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("s29_full_hold", 32'(mc_req_valid), 32'd0);
    end
    check("s29_req_count", 32'(req_done), 32'd10);
    tick(); dq_ready_r = 1'b1;
    tick(); dq_ready_r = 1'b0; pop_on_push = 1'b1;
    for (int i = 0; i < 7; i++) begin
      exp_req.push_back(32'h20 + 32'(4 * i));
      add_ent(32'h20 + 32'(4 * i), inst_of(32'h20 + 32'(4 * i)), 1'b0);
    end
    req_target = 18;
    @(negedge clk);
    check("s29_resume_valid", 32'(mc_req_valid), 32'd1);
    check("s29_resume_addr", mc_req_addr, 32'h1C);

    // Streaming with pop on every push: queue never empties, order held across wrap
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("s31_dq_valid", 32'(dq_valid), 32'd1);
    end
    wait_req(18, "s31_reqs");
    repeat (3) @(negedge clk);
    tick(); pop_on_push = 1'b0; dq_ready_r = 1'b1;
    wait_drain("s31_drain");

    // Flush while waiting: stale return dropped, refetch from 0x100
    tick(); mem_lat = 5; exp_req.push_back(32'h3C); req_target = 19;
    wait_req(19, "s30_req");
    tick(); flush = 1'b1; flush_pc = 32'h100; mem_lat = 1; dq_ready_r = 1'b0;
    exp_req.push_back(32'h100); add_ent(32'h100, 32'h0010_0013, 1'b0); req_target = 20;
    @(negedge clk);
    check("s30_flush_req", 32'(mc_req_valid), 32'd0);
    tick(); flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s30_drop_req", 32'(mc_req_valid), 32'd0);
      check("s30_drop_dq", 32'(dq_valid), 32'd0);
      check("s30_drop_pdc", 32'(pdc_valid), 32'd0);
    end
    @(negedge clk);
    check("s30_refetch_valid", 32'(mc_req_valid), 32'd1);
    check("s30_refetch_addr", mc_req_addr, 32'h100);
    wait_req(20, "s30_refetch");

    // rdy low mid-WAIT freezes everything
    tick(); mem_lat = 8; exp_req.push_back(32'h104); req_target = 21;
    wait_req(21, "s32_req");
    tick(); rdy = 1'b0; dq_ready_r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s32_req_valid", 32'(mc_req_valid), 32'd0);
      check("s32_pdc_valid", 32'(pdc_valid), 32'd0);
      check("s32_dq_valid", 32'(dq_valid), 32'd1);
      check("s32_dq_pc", dq_pc, 32'h100);
    end
    tick(); rdy = 1'b1; mem_lat = 1;
    add_ent(32'h104, 32'h0010_4013, 1'b0);
    add_ent(32'h108, 32'h0010_8013, 1'b0);
    exp_req.push_back(32'h108); req_target = 22;
    wait_req(22, "s32_resume_req");
    wait_drain("s32_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
